// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter steering one of CHANNELS burst sources onto a shared bus.
// Optional stall timeout enabled by defining MUX_ARBITER_TIMEOUT_EN.
module mux_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int BUS_SIZE   = 32,
  parameter int HOLD_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS-1:0]          last,
  input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          grant,
  output logic [$clog2(CHANNELS)-1:0]  selector,
  output logic                         out_valid,
  output logic [BUS_SIZE-1:0]          out_data,
  output logic                         out_last,
  output logic [CHANNELS-1:0]          ack,
  output logic                         timeout
);
  localparam int SW = $clog2(CHANNELS);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d, pick, others;
  logic [SW-1:0]       ptr_q, ptr_d, sel, base;
  logic                busy, xfer, rel, to;

  function automatic logic [SW-1:0] wrap(input int v);
    return SW'(v % CHANNELS);
  endfunction

  always_comb begin
    sel      = '0;
    out_data = '0;
    out_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (grant_q[i]) begin
        sel      = SW'(i);
        out_data = data_in[i*BUS_SIZE +: BUS_SIZE];
        out_last = last[i];
      end
  end

  assign busy      = state_q == BUSY;
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign ack       = CHANNELS'(xfer) << sel;
  assign rel       = (xfer & out_last) | to;
  assign base      = busy ? sel : ptr_q;
  assign others    = req & ~grant_q;
  assign grant     = grant_q;
  assign selector  = sel;
  assign timeout   = to;

  // Scan downward so the nearest requester after base wins; base itself ranks last.
  always_comb begin
    pick = '0;
    for (int j = CHANNELS; j >= 1; j--)
      if (req[wrap(int'(base) + j)]) pick = CHANNELS'(1) << wrap(int'(base) + j);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!busy && |req) begin
      state_d = BUSY;
      grant_d = pick;
    end else if (busy && rel) begin
      ptr_d   = sel;
      state_d = |others ? BUSY : IDLE;
      grant_d = |others ? pick : '0;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= SW'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end

`ifdef MUX_ARBITER_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_LIMIT + 1);
  logic [HW-1:0] hold_q, hold_d;
  assign to     = busy & ~xfer & (hold_q == HW'(HOLD_LIMIT - 1));
  assign hold_d = (busy & ~xfer & ~to) ? hold_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) hold_q <= '0;
    else hold_q <= hold_d;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_LIMIT;
  assign to          = 1'b0;
`endif
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed self-checking bench for mux_arbiter (CHANNELS=4, BUS_SIZE=32).
module tb_mux_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, last, grant, ack;
  logic [127:0] data_in;
  logic         out_ready, out_valid, out_last, timeout;
  logic [1:0]   selector;
  logic [31:0]  out_data;
  logic [31:0]  slice [4];
  int checks = 0;
  int errors = 0;

  mux_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .data_in(data_in),
    .out_ready(out_ready), .grant(grant), .selector(selector), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .ack(ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pack();
    data_in = {slice[3], slice[2], slice[1], slice[0]};
    #1;
  endtask

  initial begin
    slice[0] = 32'hAAAA0000; slice[1] = 32'hBBBB0001;
    slice[2] = 32'hCCCC0002; slice[3] = 32'hDDDD0003;
    reset = 1'b0; req = '0; last = '0; out_ready = 1'b0;
    pack();
    tick(); tick();
    chk("rst_grant", grant, 0); chk("rst_sel", selector, 0); chk("rst_valid", out_valid, 0);
    chk("rst_ack", ack, 0); chk("rst_timeout", timeout, 0); chk("rst_data", out_data, 0);
    reset = 1'b1;
    // Alternating pair 0/2, single-beat bursts, no idle gap
    req = 4'b0101; last = 4'b1111; out_ready = 1'b1; #1;
    chk("alt_idle", grant, 0); chk("alt_idle_valid", out_valid, 0);
    tick(); #1;
    chk("alt_g0", grant, 4'b0001); chk("alt_sel0", selector, 0); chk("alt_v0", out_valid, 1);
    chk("alt_ack0", ack, 4'b0001); chk("alt_d0", out_data, slice[0]); chk("alt_l0", out_last, 1);
    tick(); #1;
    chk("alt_g2", grant, 4'b0100); chk("alt_sel2", selector, 2);
    chk("alt_ack2", ack, 4'b0100); chk("alt_d2", out_data, slice[2]);
    tick(); #1;
    chk("alt_g0b", grant, 4'b0001);
    req = 4'b0001; #1;
    chk("alt_ack0b", ack, 4'b0001);
    tick(); #1;
    chk("solo_idle", grant, 0); chk("solo_idle_v", out_valid, 0);
    chk("solo_idle_sel", selector, 0); chk("solo_idle_d", out_data, 0);
    tick(); #1;
    chk("solo_regrant", grant, 4'b0001);
    req = 4'b0000; #1;
    chk("drop_valid", out_valid, 0); chk("drop_ack", ack, 0);
    tick(); #1;
    chk("drop_hold", grant, 4'b0001);
    req = 4'b0001; last = 4'b0000; out_ready = 1'b0; #1;
    chk("stall_valid", out_valid, 1); chk("stall_ack", ack, 0); chk("stall_to", timeout, 0);
    tick();
    out_ready = 1'b1; last = 4'b0001; #1;
    chk("end_ack", ack, 4'b0001); chk("end_last", out_last, 1);
    tick();
    // Channel 2 three-beat burst with a stall on beat 2
    req = 4'b0100; last = 4'b0000; #1;
    chk("b3_idle", grant, 0);
    tick(); #1;
    chk("b3_g1", grant, 4'b0100); chk("b3_ack1", ack, 4'b0100);
    chk("b3_d1", out_data, slice[2]); chk("b3_l1", out_last, 0);
    tick();
    out_ready = 1'b0; #1;
    chk("b3_gs", grant, 4'b0100); chk("b3_vs", out_valid, 1); chk("b3_acks", ack, 0);
    tick();
    out_ready = 1'b1; slice[2] = 32'h12345678; pack();
    chk("b3_g2", grant, 4'b0100); chk("b3_ack2", ack, 4'b0100); chk("b3_d2", out_data, 32'h12345678);
    tick();
    last = 4'b0100; slice[2] = 32'h0BADF00D; pack();
    chk("b3_g3", grant, 4'b0100); chk("b3_ack3", ack, 4'b0100);
    chk("b3_d3", out_data, 32'h0BADF00D); chk("b3_l3", out_last, 1);
    tick(); #1;
    chk("b3_release", grant, 0);
    // Reset during beat 2 of a channel 1 burst
    req = 4'b0010; last = 4'b0000; #1;
    tick(); #1;
    chk("r1_g", grant, 4'b0010); chk("r1_ack", ack, 4'b0010); chk("r1_d", out_data, slice[1]);
    tick();
    reset = 1'b0; #1;
    chk("r1_rst_g", grant, 0); chk("r1_rst_v", out_valid, 0);
    chk("r1_rst_ack", ack, 0); chk("r1_rst_sel", selector, 0);
    tick();
    reset = 1'b1; #1;
    chk("r1_post_idle", grant, 0);
    tick(); #1;
    chk("r1_regrant", grant, 4'b0010); chk("r1_regrant_sel", selector, 1);
    last = 4'b0010; #1;
    chk("r1_end_ack", ack, 4'b0010);
    tick();
    // Full contention rotation from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 4'b1111; last = 4'b1111; out_ready = 1'b1; #1;
    chk("rot_idle", grant, 0);
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      chk($sformatf("rot_g%0d", k), grant, 4'b0001 << (k % 4));
      chk($sformatf("rot_sel%0d", k), selector, k % 4);
      chk($sformatf("rot_ack%0d", k), ack, 4'b0001 << (k % 4));
      chk($sformatf("rot_d%0d", k), out_data, slice[k % 4]);
    end
`ifdef MUX_ARBITER_TIMEOUT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1; req = 4'b1000; last = 4'b0000; out_ready = 1'b0; #1;
    tick();
    req = 4'b1001; #1;
    chk("to_g3", grant, 4'b1000);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("to_quiet%0d", k), timeout, 0);
      tick(); #1;
    end
    chk("to_pulse", timeout, 1); chk("to_hold", grant, 4'b1000);
    tick(); #1;
    chk("to_move", grant, 4'b0001); chk("to_clear", timeout, 0);
`else
    chk("to_tied", timeout, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of requesters sharing the bus (2 to 16).
REQ-002 The block SHALL have parameter BUS_SIZE, default 32: data bits per channel.
REQ-003 The block SHALL have parameter HOLD_LIMIT, default 16: cycles a grant may stall before forced release (timeout feature only).
REQ-004 clk  input  1  Clock; all state updates on the rising edge.
REQ-005 reset  input  1  Asynchronous reset, active low.
REQ-006 req  input  CHANNELS  Per-requester request; bit i = channel i.
REQ-007 last  input  CHANNELS  Per-requester end-of-burst flag, sampled with that channel's beat.
REQ-008 data_in  input  CHANNELS*BUS_SIZE  Packed channel data; channel i occupies bits [i*BUS_SIZE +: BUS_SIZE].
REQ-009 out_ready  input  1  Downstream accepts the current beat.
REQ-010 grant  output  CHANNELS  One-hot registered grant.
REQ-011 selector  output  $clog2(CHANNELS)  Binary index of the granted channel; drives the shared mux selector.
REQ-012 out_valid  output  1  Beat valid on the shared bus.
REQ-013 out_data  output  BUS_SIZE  Data of the granted channel.
REQ-014 out_last  output  1  last bit of the granted channel.
REQ-015 ack  output  CHANNELS  Per-requester beat-accepted strobe.
REQ-016 timeout  output  1  One-cycle pulse on forced release.

Function
REQ-017 The FSM SHALL have two states, IDLE and BUSY; grant SHALL be all-zero in IDLE and exactly one-hot in BUSY.
REQ-018 In IDLE with any req bit set, the FSM SHALL register a grant to the first requesting channel after the last-granted pointer, modulo CHANNELS, and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-019 selector SHALL equal the binary encoding of grant; it SHALL be 0 in IDLE.
REQ-020 out_data and out_last SHALL be combinational selections of the granted channel's slice of data_in and last; out_data SHALL be 0 in IDLE.
REQ-021 out_valid SHALL be (state == BUSY) AND req[selector].
REQ-022 A beat SHALL transfer when out_valid AND out_ready; ack[selector] SHALL be high in that cycle only, and all other ack bits SHALL be 0.
REQ-023 In BUSY, grant SHALL be held across stalls, out_ready low, and req deasserted without last; there is no release without a last beat or a timeout.
REQ-024 On a transferring beat with out_last=1, the pointer SHALL update to the granted index; if any other channel requests, the next grant SHALL be issued on the next edge with the FSM remaining in BUSY (no idle bubble); otherwise the FSM SHALL return to IDLE.
REQ-025 After a last beat, the releasing channel SHALL have the lowest priority in the next arbitration; if it is the only requester, it SHALL be re-granted.
REQ-026 Simultaneous requests from all channels SHALL be served in strict rotation, with each channel granted once per CHANNELS bursts.
REQ-027 req changes in the same cycle as a last beat SHALL be evaluated using the current-cycle req value.

Reset
REQ-028 While reset is low, state SHALL be IDLE, grant=0, selector=0, pointer=CHANNELS-1 so channel 0 wins first, out_valid=0, ack=0, timeout=0, and the hold counter SHALL be 0.
REQ-029 Reset asserted mid-burst SHALL drop the grant immediately, with no ack generated; deassertion SHALL be followed by a fresh arbitration.

Configuration
REQ-030 With MUX_ARBITER_TIMEOUT_EN defined, a hold counter SHALL count consecutive BUSY cycles without a transfer, clear on any transfer or new grant, and on reaching HOLD_LIMIT SHALL pulse timeout for 1 cycle and release the grant as if a last beat had occurred, with the pointer advanced past the stalled channel.
REQ-031 Without MUX_ARBITER_TIMEOUT_EN, timeout SHALL be tied to 0, no counter SHALL be synthesized, and HOLD_LIMIT SHALL be ignored.

Verification
REQ-032 Reset, then req=4'b0101 held with last=1 and out_ready=1: grant sequence SHALL be 0001, 0100, 0001, each burst one beat, with no idle cycle between grants.
REQ-033 Channel 2 sends a 3-beat burst and out_ready is low on beat 2: grant stays 0100 for 4 cycles, ack[2] pulses 3 times, and out_data matches the channel 2 slice on every beat.
REQ-034 req=4'b1111 with single-beat bursts for 8 bursts: grants SHALL rotate 0,1,2,3,0,1,2,3.
REQ-035 Reset asserted during beat 2 of a channel 1 burst: grant=0 and out_valid=0 immediately; after release with req=0010, channel 1 is granted 1 cycle later.
REQ-036 With MUX_ARBITER_TIMEOUT_EN and HOLD_LIMIT=16, channel 3 is granted and out_ready is held 0: timeout pulses once after 16 stalled cycles, and grant moves to pending channel 0.
